add12u_share_sched: RTL and testbench

- Time-shares one external 12-bit unsigned adder (any add12u variant, exact or approximate) among NREQ requesters.
- Each requester presents operand pairs on a valid/ready handshake. The scheduler grants round-robin, drives the shared adder, registers its 13-bit output and returns it tagged with the requester ID.
- Sits between accelerator lanes and a single adder instance, so adder variants can be swapped without touching the lanes.

---
 rtl/add12u_sched_pkg.sv | 36 +++
 rtl/add12u_share_sched_rr_arbiter.sv | 38 +++
 rtl/add12u_share_sched.sv | 121 ++++++++++++
 tb/tb_add12u_share_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add12u_sched_pkg.sv
// Shared types and the round-robin pick helper for the add12u time-sharing scheduler.
package add12u_sched_pkg;

  localparam int OPW    = 12;
  localparam int SUMW   = 13;
  localparam int MAXREQ = 8;

  typedef logic [OPW-1:0]  operand_t;
  typedef logic [SUMW-1:0] sum_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  // One-hot grant for the first asserted valid at or after ptr, wrapping at n.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                               input logic [2:0]        ptr,
                                               input logic [3:0]        n);
    logic [MAXREQ-1:0] g;
    logic              found;
    logic [3:0]        idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if ((4'(k) < n) && !found && valid[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/add12u_share_sched_rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer, advances it past each accepted grant.
module rr_arbiter
  import add12u_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            advance_en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [MAXREQ-1:0] pick;

  always_comb begin
    pick      = rr_pick(MAXREQ'(valid), 3'(rr_ptr_q), 4'(NREQ));
    grant     = NREQ'(pick);
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
    rr_ptr_d = rr_ptr_q;
    // Explicit wrap keeps the pointer inside 0..NREQ-1 for non-power-of-2 NREQ.
    if (advance_en && |grant) begin
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/add12u_share_sched.sv
// Time-shares one external 12-bit adder among NREQ requesters; single-entry tagged result buffer.
// Optional mismatch monitor against an exact sum is built when ADD12U_SCHED_ERRMON_EN is defined.
module add12u_share_sched
  import add12u_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
`ifdef ADD12U_SCHED_ERRMON_EN
  input  logic                clr_err,
  output logic [15:0]         err_cnt,
  output sum_t                err_max,
`endif
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output operand_t            add_a,
  output operand_t            add_b,
  input  sum_t                add_o,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output sum_t                rsp_sum
);

  // state | meaning
  // EMPTY | no result held ; FULL | result held in rsp_* until rsp_ready
  rsp_state_e      state_q, state_d;
  sum_t            rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            can_accept, handshake;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      (req_valid),
    .advance_en (handshake),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    req_ready  = (can_accept && !rst) ? grant : '0;
    handshake  = |req_ready;
    add_a      = '0;
    add_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i] && !rst) begin
        add_a = req_a[OPW*i +: OPW];
        add_b = req_b[OPW*i +: OPW];
      end
    end
    rsp_sum_d = rsp_sum_q;
    rsp_id_d  = rsp_id_q;
    if (handshake) begin
      rsp_sum_d = add_o;
      rsp_id_d  = grant_idx;
    end
    state_d = state_q;
    case (state_q)
      EMPTY:   if (handshake) state_d = FULL;
      FULL:    if (!handshake && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADD12U_SCHED_ERRMON_EN
  sum_t        exact_sum, err_diff, err_max_q, err_max_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    exact_sum = SUMW'(add_a) + SUMW'(add_b);
    err_diff  = (exact_sum >= add_o) ? exact_sum - add_o : add_o - exact_sum;
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (clr_err) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (handshake && (err_diff != '0)) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
      if (err_diff > err_max_q) err_max_d = err_diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_add12u_share_sched.sv
// Scoreboard bench for add12u_share_sched with an exact adder stub (optional +5 fault injection).
module tb_add12u_share_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*12-1:0] req_a, req_b;
  logic [11:0]   add_a, add_b;
  logic [12:0]   add_o;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [12:0]   rsp_sum;
  logic          inj_en;
`ifdef ADD12U_SCHED_ERRMON_EN
  logic          clr_err;
  logic [15:0]   err_cnt;
  logic [12:0]   err_max;
`endif

  add12u_share_sched #(.NREQ(N)) dut (
`ifdef ADD12U_SCHED_ERRMON_EN
    .clr_err   (clr_err),
    .err_cnt   (err_cnt),
    .err_max   (err_max),
`endif
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_o     (add_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  always #5 clk = ~clk;

  // Adder stub: exact, or exact+5 for A>=0x800 while injection is enabled.
  assign add_o = 13'(add_a) + 13'(add_b) + ((inj_en && add_a >= 12'h800) ? 13'd5 : 13'd0);

  int n_chk = 0, n_pass = 0;
  int cyc = 0, rsp_cnt = 0, last_pop_cyc = 0;
  logic [23:0] rq [N][$];
  int exp_id_q[$], exp_sum_q[$];
  logic [N-1:0] hs_pend = '0;
  logic rsp_rdy_ctl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_req(input int i, input logic [11:0] a, input logic [11:0] b);
    rq[i].push_back({a, b});
  endtask

  task automatic exp_rsp(input int id, input int sum);
    exp_id_q.push_back(id);
    exp_sum_q.push_back(sum);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((pending() > 0 || exp_id_q.size() > 0) && k < 100) begin
      @(negedge clk);
      #4;
      k++;
    end
    check({name, "_done"}, 32'(pending() == 0 && exp_id_q.size() == 0), 1);
  endtask

  // Requester driver: present queue heads, retire them after an observed handshake.
  always @(negedge clk) begin : drv
    logic [N-1:0]    v;
    logic [N*12-1:0] av, bv;
    for (int i = 0; i < N; i++)
      if (hs_pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    v = '0; av = '0; bv = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        v[i]          = 1'b1;
        av[12*i +: 12] = rq[i][0][23:12];
        bv[12*i +: 12] = rq[i][0][11:0];
      end
    end
    req_valid = v;
    req_a     = av;
    req_b     = bv;
    rsp_ready = rsp_rdy_ctl;
    #1;
    hs_pend = req_valid & req_ready;
  end

  // Monitor: every accepted response must match the scoreboard head.
  always @(negedge clk) begin : mon
    int eid, esum;
    #2;
    cyc++;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("sb_nonempty", 32'(exp_id_q.size() > 0), 1);
      if (exp_id_q.size() > 0) begin
        eid  = exp_id_q.pop_front();
        esum = exp_sum_q.pop_front();
        check("rsp_id", 32'(rsp_id), eid);
        check("rsp_sum", 32'(rsp_sum), esum);
      end
      rsp_cnt++;
      last_pop_cyc = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int base, c0, c1, k;
    rst = 1'b1; rsp_rdy_ctl = 1'b0; inj_en = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
`ifdef ADD12U_SCHED_ERRMON_EN
    clr_err = 1'b0;
`endif
    repeat (3) step();
    @(negedge clk); #3;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_add_a", 32'(add_a), 0);
`ifdef ADD12U_SCHED_ERRMON_EN
    check("rst_err_cnt", 32'(err_cnt), 0);
`endif
    step(); rst = 1'b0; rsp_rdy_ctl = 1'b1;

    // Single request, 1-cycle latency.
    step();
    push_req(2, 12'h7FF, 12'h801); exp_rsp(2, 'h1000);
    @(negedge clk); #3;
    check("t1_req_ready", 32'(req_ready), 32'b0100);
    @(negedge clk); #3;
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_id", 32'(rsp_id), 2);
    check("t1_rsp_sum", 32'(rsp_sum), 'h1000);
    wait_idle("t1");

    // All four valid, pointer starts at 3.
    step();
    base = rsp_cnt;
    push_req(0, 12'h001, 12'h002); push_req(0, 12'hFFF, 12'h001);
    push_req(1, 12'h010, 12'h020); push_req(1, 12'hFFF, 12'hFFF);
    push_req(2, 12'h100, 12'h200); push_req(2, 12'h800, 12'h800);
    push_req(3, 12'hABC, 12'h123); push_req(3, 12'h000, 12'h000);
    exp_rsp(3, 'hBDF); exp_rsp(0, 'h003); exp_rsp(1, 'h030); exp_rsp(2, 'h300);
    exp_rsp(3, 'h000); exp_rsp(0, 'h1000); exp_rsp(1, 'h1FFE); exp_rsp(2, 'h1000);
    k = 0;
    while (rsp_cnt < base + 1 && k < 50) begin @(negedge clk); #4; k++; end
    c0 = last_pop_cyc;
    while (rsp_cnt < base + 8 && k < 50) begin @(negedge clk); #4; k++; end
    c1 = last_pop_cyc;
    check("t2_rsp_count", 32'(rsp_cnt - base), 8);
    check("t2_no_bubble", 32'(c1 - c0), 7);
    wait_idle("t2");

    // Backpressure for 3 cycles while FULL.
    step();
    rsp_rdy_ctl = 1'b0;
    push_req(1, 12'h123, 12'h456); push_req(2, 12'h00F, 12'h001);
    exp_rsp(1, 'h579); exp_rsp(2, 'h010);
    @(negedge clk); #3;
    check("t3_first_grant", 32'(req_ready), 32'b0010);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #3;
      check("t3_stall_ready", 32'(req_ready), 0);
      check("t3_stall_valid", 32'(rsp_valid), 1);
      check("t3_stall_sum", 32'(rsp_sum), 'h579);
      check("t3_stall_id", 32'(rsp_id), 1);
    end
    step(); rsp_rdy_ctl = 1'b1;
    @(negedge clk); #3;
    check("t3_drain_grant", 32'(req_ready), 32'b0100);
    wait_idle("t3");

    // Requesters 1 and 3 with pointer at 2.
    step();
    push_req(1, 12'h001, 12'h001); exp_rsp(1, 'h002);
    wait_idle("t4a");
    step();
    push_req(1, 12'h200, 12'h300); push_req(3, 12'h7FF, 12'h7FF);
    exp_rsp(3, 'hFFE); exp_rsp(1, 'h500);
    wait_idle("t4b");
    step();
    push_req(1, 12'h005, 12'h005); push_req(2, 12'h00C, 12'h004);
    exp_rsp(2, 'h010); exp_rsp(1, 'h00A);
    wait_idle("t4c");

    // Reset while FULL: the held result is discarded, pointer returns to 0.
    step();
    rsp_rdy_ctl = 1'b0;
    push_req(2, 12'h0AA, 12'h055);
    @(negedge clk);
    @(negedge clk); #3;
    check("t5_full", 32'(rsp_valid), 1);
    check("t5_held_sum", 32'(rsp_sum), 'h0FF);
    step();
    rst = 1'b1;
    push_req(0, 12'h001, 12'h000); push_req(3, 12'h333, 12'h111);
    exp_rsp(0, 'h001); exp_rsp(3, 'h444);
    @(negedge clk); #3;
    check("t5_rst_ready", 32'(req_ready), 0);
    check("t5_rst_add_a", 32'(add_a), 0);
    check("t5_rst_add_b", 32'(add_b), 0);
    @(negedge clk); #3;
    check("t5_rst_valid", 32'(rsp_valid), 0);
    check("t5_rst_sum", 32'(rsp_sum), 0);
    step();
    rst = 1'b0; rsp_rdy_ctl = 1'b1;
    wait_idle("t5");

`ifdef ADD12U_SCHED_ERRMON_EN
    step(); clr_err = 1'b1;
    step(); clr_err = 1'b0; inj_en = 1'b1;
    push_req(0, 12'h800, 12'h001); push_req(0, 12'h100, 12'h200);
    push_req(1, 12'h900, 12'h100);
    push_req(2, 12'hFFF, 12'h001);
    push_req(3, 12'h7FF, 12'h001);
    exp_rsp(0, 'h806); exp_rsp(1, 'hA05); exp_rsp(2, 'h1005); exp_rsp(3, 'h800); exp_rsp(0, 'h300);
    wait_idle("t6");
    @(negedge clk); #3;
    check("t6_err_cnt", 32'(err_cnt), 3);
    check("t6_err_max", 32'(err_max), 5);
    step(); clr_err = 1'b1;
    step(); clr_err = 1'b0;
    @(negedge clk); #3;
    check("t6_clr_cnt", 32'(err_cnt), 0);
    check("t6_clr_max", 32'(err_max), 0);
    inj_en = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #4;
    check("sb_empty", 32'(exp_id_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
